demux_1x4_32b: RTL and testbench
================================

# demux_1x4_32b

Registered 1-to-4 demultiplexer for 32-bit words, the distribution counterpart of the 4-to-1 32-bit selector. One input word with a 2-bit destination select is steered into one of four single-entry output slots, each with its own valid/ready handshake. It sits where one producer feeds four consumers (e.g. a result bus fanned out to four register-file or unit inputs), buffering one word per destination so a stalled consumer blocks only its own channel.

## Interface

- No parameters; data width fixed at 32, channel count fixed at 4.
- `clk  input  1`: single clock, all state updates on rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `s  input  2`: destination select; 00→A, 01→B, 10→C, 11→D.
- `X  input  32`: input data word.
- `in_valid  input  1`: X/s valid this cycle.
- `in_ready  output  1`: demux accepts X this cycle.
- `A, B, C, D  output  32 each`: slot data, channels 0..3.
- `vA, vB, vC, vD  output  1 each`: slot holds a valid word.
- `rA, rB, rC, rD  input  1 each`: consumer takes the slot word this cycle.

## Operation

- Per channel k: full flag F[k], 32-bit data register R[k]; output data = R[k], valid = F[k].
- Accept: `acc = in_valid & in_ready`, with `in_ready = ~F[s] | r[s]` (only the selected channel is consulted).
- Drain of channel k: `drn[k] = F[k] & r[k]`.
- Next state per channel k, `ld[k] = acc & (s == k)`:
  - ld[k]: R[k] ← X, F[k] ← 1 (regardless of drn[k]; simultaneous drain + load = pass-through replace).
  - else drn[k]: F[k] ← 0, R[k] holds.
  - else: hold.
- Non-selected channels drain independently in the same cycle as a load to another channel.
- r[k] while F[k]=0 is ignored; no state change.
- X and s ignored when in_valid=0; in_ready still driven combinationally from s.
- R[k] retains its last value after drain (not cleared); consumers must qualify with valid.
- Reset (rst=1 at edge): all F[k]=0, all R[k]=32'h0; overrides any load/drain in the same cycle. Reset mid-transfer discards buffered words; no partial state survives.

## Timing

- Load latency: word accepted at edge n is visible on the output with valid=1 after edge n (same cycle as n+1 sampling), i.e. 1 cycle.
- Throughput: 1 word/cycle to one channel while its consumer holds r=1; 1 word/cycle total across channels.
- Combinational paths: s, rA..rD → in_ready only; in_ready ≤ 500 ps (same budget as the 4:1 selector, built from the same AND/OR select structure). No combinational path from X or in_valid to any output.
- All outputs registered except in_ready.
- Values after reset: in_ready = 1 (all slots empty), vA..vD = 0, A..D = 0.

## Structure

- Sub-module `demux_slot_32b`: one channel (F flag, 32-bit register, load/drain/reset logic); instantiated four times.
- Top level: 2→4 select decode (ld[k]), 4:1 selection of F/r for in_ready (reuse `mux_4x1` for the ~F|r term).
- Shared defines file: data width 32, channel codes CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11; shared with the selector-side code.

## Test plan

- Reset: assert rst 2 cycles with in_valid=1, s=10, X=32'hFFFF_FFFF → all v=0, A..D=0, in_ready=1 after release.
- Fan-out: all r=1; send s=00,01,10,11 with X=32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 on consecutive cycles → each appears on A,B,C,D respectively one cycle later, v pulses 1 cycle each.
- Back-pressure: rB=0; send s=01 X=32'hDEAD_BEEF, then s=01 X=32'hCAFE_F00D → first held on B with vB=1, in_ready=0 for s=01; second accepted the cycle rB rises, B=32'hCAFE_F00D next cycle, no loss/duplication.
- Isolation: rC=0, C full; send s=00 X=32'h0000_00A5 → in_ready=1, A=32'h0000_00A5 next cycle while C unchanged.
- Simultaneous drain+load on D with rD=1 continuous, 8 back-to-back words 0..7 → D shows 0..7 in order, vD stays 1, in_ready stays 1.
- Reset mid-operation: A and C full, rst=1 with in_valid=1 → next cycle vA=vC=0, A=C=0, load discarded.

Source files
------------

// File: rtl/demux_1x4_32b_pkg.sv
// Shared definitions for the 1-to-4 32-bit demultiplexer: width, channel codes
// and the 4:1 select helper reused for the in_ready term.
package demux_1x4_32b_pkg;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    CH_A = 2'b00,
    CH_B = 2'b01,
    CH_C = 2'b10,
    CH_D = 2'b11
  } ch_e;

  function automatic logic mux_4x1(input logic [1:0] sel, input logic [3:0] d);
    logic y;
    case (sel)
      2'b00:   y = d[0];
      2'b01:   y = d[1];
      2'b10:   y = d[2];
      2'b11:   y = d[3];
      default: y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/demux_1x4_32b_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-4 demultiplexer.
// The master modport is the environment (producer plus four consumers).
interface demux_1x4_32b_if;
  import demux_1x4_32b_pkg::*;

  logic [1:0]        s;
  logic [DATA_W-1:0] X;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] A, B, C, D;
  logic              vA, vB, vC, vD;
  logic              rA, rB, rC, rD;

  modport master (
    output s, X, in_valid, rA, rB, rC, rD,
    input  in_ready, A, B, C, D, vA, vB, vC, vD
  );

  modport slave (
    input  s, X, in_valid, rA, rB, rC, rD,
    output in_ready, A, B, C, D, vA, vB, vC, vD
  );
endinterface

// File: rtl/demux_1x4_32b_slot.sv
// One single-entry output channel: full flag plus data register.
// A load wins over a same-cycle drain, giving pass-through replacement.
module demux_slot_32b
  import demux_1x4_32b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ld,
  input  logic              i_rdy,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;

  // Data is kept after a drain; consumers qualify it with o_full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= 32'h0000_0000;
    end else if (i_ld) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_rdy) begin
      r_full <= 1'b0;
      r_data <= r_data;
    end else begin
      r_full <= r_full;
      r_data <= r_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/demux_1x4_32b.sv
// Registered 1-to-4 demultiplexer: steers one 32-bit word per cycle into one of
// four buffered channels; only the selected channel gates in_ready.
module demux_1x4_32b
  import demux_1x4_32b_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  demux_1x4_32b_if.slave bus
);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_rdy;
  logic [NUM_CH-1:0] w_ld;
  logic [DATA_W-1:0] w_data [NUM_CH];
  logic              w_in_ready;

  assign w_rdy      = {bus.rD, bus.rC, bus.rB, bus.rA};
  assign w_in_ready = mux_4x1(bus.s, ~w_full | w_rdy);

  // Decode the destination into a one-hot load strobe for an accepted word.
  always_comb begin
    w_ld = 4'b0000;
    if (bus.in_valid && w_in_ready) begin
      case (ch_e'(bus.s))
        CH_A:    w_ld = 4'b0001;
        CH_B:    w_ld = 4'b0010;
        CH_C:    w_ld = 4'b0100;
        CH_D:    w_ld = 4'b1000;
        default: w_ld = 4'b0000;
      endcase
    end else begin
      w_ld = 4'b0000;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot_32b u_slot (
      .clk    (clk),
      .rst    (rst),
      .i_ld   (w_ld[k]),
      .i_rdy  (w_rdy[k]),
      .i_data (bus.X),
      .o_full (w_full[k]),
      .o_data (w_data[k])
    );
  end

  assign bus.in_ready = w_in_ready;
  assign bus.A  = w_data[0];
  assign bus.B  = w_data[1];
  assign bus.C  = w_data[2];
  assign bus.D  = w_data[3];
  assign bus.vA = w_full[0];
  assign bus.vB = w_full[1];
  assign bus.vC = w_full[2];
  assign bus.vD = w_full[3];

endmodule

// File: tb/tb_demux_1x4_32b.sv
// Scoreboard bench for demux_1x4_32b: accepted words are queued per channel
// and compared against the slot outputs every cycle until consumed.
module tb_demux_1x4_32b;
  import demux_1x4_32b_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] q [4][$];

  demux_1x4_32b_if bus ();

  demux_1x4_32b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic get_v(input int k);
    case (k)
      0:       return bus.vA;
      1:       return bus.vB;
      2:       return bus.vC;
      default: return bus.vD;
    endcase
  endfunction

  function automatic logic [31:0] get_d(input int k);
    case (k)
      0:       return bus.A;
      1:       return bus.B;
      2:       return bus.C;
      default: return bus.D;
    endcase
  endfunction

  // Check current outputs against the model, advance the model, then clock.
  task automatic cyc();
    logic [3:0] r;
    logic       exp_rdy;
    #1;
    r = {bus.rD, bus.rC, bus.rB, bus.rA};
    exp_rdy = (q[bus.s].size() == 0) || r[bus.s];
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("valid%0d", k), {31'd0, get_v(k)}, {31'd0, (q[k].size() != 0)});
      if (q[k].size() != 0) chk($sformatf("data%0d", k), get_d(k), q[k][0]);
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++)
        if (q[k].size() != 0 && r[k]) void'(q[k].pop_front());
      if (bus.in_valid && exp_rdy) q[bus.s].push_back(bus.X);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] x);
    bus.in_valid = v;
    bus.s        = sel;
    bus.X        = x;
  endtask

  task automatic set_r(input logic [3:0] r);
    {bus.rD, bus.rC, bus.rB, bus.rA} = r;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 2'b10, 32'hFFFF_FFFF);
    set_r(4'b0000);
    @(posedge clk);
    #1;
    // Reset held two cycles with a valid word presented.
    cyc();
    cyc();
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0000_0000);
    #1;
    chk("rst_A", bus.A, 32'h0);
    chk("rst_B", bus.B, 32'h0);
    chk("rst_C", bus.C, 32'h0);
    chk("rst_D", bus.D, 32'h0);
    chk("rst_v", {28'd0, bus.vD, bus.vC, bus.vB, bus.vA}, 32'h0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'h1);
    cyc();

    // Fan-out across all channels.
    set_r(4'b1111);
    drive(1'b1, 2'b00, 32'h1111_1111); cyc();
    drive(1'b1, 2'b01, 32'h2222_2222); cyc();
    drive(1'b1, 2'b10, 32'h3333_3333); cyc();
    drive(1'b1, 2'b11, 32'h4444_4444); cyc();
    drive(1'b0, 2'b00, 32'h0000_0000); cyc();
    cyc();

    // Back-pressure on B.
    set_r(4'b1101);
    drive(1'b1, 2'b01, 32'hDEAD_BEEF); cyc();
    drive(1'b1, 2'b01, 32'hCAFE_F00D);
    #1;
    chk("bp_rdy", {31'd0, bus.in_ready}, 32'h0);
    chk("bp_B", bus.B, 32'hDEAD_BEEF);
    cyc();
    cyc();
    set_r(4'b1111); cyc();
    drive(1'b0, 2'b00, 32'h0000_0000);
    #1;
    chk("bp_B2", bus.B, 32'hCAFE_F00D);
    cyc();
    cyc();

    // Isolation: C stalled and full, A still accepts.
    set_r(4'b1011);
    drive(1'b1, 2'b10, 32'h0000_0077); cyc();
    drive(1'b1, 2'b00, 32'h0000_00A5);
    #1;
    chk("iso_rdy", {31'd0, bus.in_ready}, 32'h1);
    cyc();
    drive(1'b0, 2'b00, 32'h0000_0000);
    #1;
    chk("iso_A", bus.A, 32'h0000_00A5);
    chk("iso_C", bus.C, 32'h0000_0077);
    cyc();
    set_r(4'b1111); cyc();
    cyc();

    // Pass-through stream on D.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b11, 32'(i));
      cyc();
    end
    drive(1'b0, 2'b00, 32'h0000_0000); cyc();
    cyc();

    // Reset while A and C hold words and a load is presented.
    set_r(4'b0000);
    drive(1'b1, 2'b00, 32'h0000_0AAA); cyc();
    drive(1'b1, 2'b10, 32'h0000_0CCC); cyc();
    rst = 1'b1;
    drive(1'b1, 2'b01, 32'h0000_0BBB); cyc();
    rst = 1'b0;
    drive(1'b0, 2'b00, 32'h0000_0000);
    #1;
    chk("mid_A", bus.A, 32'h0);
    chk("mid_C", bus.C, 32'h0);
    chk("mid_v", {28'd0, bus.vD, bus.vC, bus.vB, bus.vA}, 32'h0);
    cyc();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      set_r(4'($urandom_range(0, 15)));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom());
      cyc();
    end
    set_r(4'b1111);
    drive(1'b0, 2'b00, 32'h0000_0000);
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
